addsub_pipe_ctrl: RTL

//   Two-stage valid/ready pipeline wrapped around the ripple add/sub datapath.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_core.sv | 33 +++
 rtl/addsub_pipe_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and request/response bundles for the add/sub pipeline.
// The flag fields of addsub_rsp_t read as 0 when ADDSUB_FLAGS_EN is undefined.
package addsub_pkg;

  localparam int ADDSUB_W = 4;

  typedef struct packed {
    logic [ADDSUB_W-1:0] a;
    logic [ADDSUB_W-1:0] b;
    logic                sub;
  } addsub_req_t;

  typedef struct packed {
    logic [ADDSUB_W-1:0] sum;
    logic                cout;
    logic                ovf;
    logic                zero;
    logic                neg;
  } addsub_rsp_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple-carry adder/subtractor.
// Subtraction is A + ~B + 1, so cout=1 means "no borrow".
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign cout = carry[WIDTH];
  // Signed overflow: like-signed operands produced a result of the other sign.
  assign ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_pipe_ctrl.sv
// Two-stage valid/ready pipeline around addsub_core with backpressure and flush.
// Define ADDSUB_FLAGS_EN to register out_ovf/out_zero/out_neg; otherwise they are tied 0.
module addsub_pipe_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  logic             s1_valid_reg, s1_valid_next;
  logic             s2_valid_reg, s2_valid_next;
  logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
  logic             s1_sub_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             s2_free, s1_adv, accept, s2_load;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_ovf;

  // in_ready depends on out_ready and flush only, never on in_valid.
  assign s2_free  = !s2_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_free;
  assign in_ready = (!s1_valid_reg || s1_adv) && !flush;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_adv && !flush;

  always_comb begin
    s1_valid_next = s1_valid_reg;
    s2_valid_next = s2_valid_reg;
    if (flush) begin
      s1_valid_next = 1'b0;
      s2_valid_next = 1'b0;
    end else begin
      if (accept)
        s1_valid_next = 1'b1;
      else if (s1_adv)
        s1_valid_next = 1'b0;
      if (s1_adv)
        s2_valid_next = 1'b1;
      else if (out_ready)
        s2_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s2_valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_reg   <= '0;
      s1_b_reg   <= '0;
      s1_sub_reg <= 1'b0;
    end else if (accept) begin
      s1_a_reg   <= in_a;
      s1_b_reg   <= in_b;
      s1_sub_reg <= in_sub;
    end
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (s1_a_reg),
    .b    (s1_b_reg),
    .sub  (s1_sub_reg),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // Result registers move only on an S2 load; a flush leaves their contents alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (s2_load) begin
      sum_reg  <= core_sum;
      cout_reg <= core_cout;
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic ovf_reg, zero_reg, neg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (s2_load) begin
      ovf_reg  <= core_ovf;
      zero_reg <= (core_sum == '0);
      neg_reg  <= core_sum[WIDTH-1];
    end
  end

  assign out_ovf  = ovf_reg;
  assign out_zero = zero_reg;
  assign out_neg  = neg_reg;
`else
  logic unused_core_ovf;
  assign unused_core_ovf = core_ovf;
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

  assign out_valid = s2_valid_reg;
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

endmodule
